// File: rtl/core_sequencer_if.sv
// Fetch and data-memory handshake bundle between the core sequencer and its memories.
// The master side is the sequencer; the slave side is the memory subsystem.
interface core_sequencer_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_rdata;
    logic            mem_req;
    logic            mem_we;
    logic            mem_ready;

    modport master (
        output imem_req, imem_addr, mem_req, mem_we,
        input  imem_valid, imem_rdata, mem_ready
    );

    modport slave (
        input  imem_req, imem_addr, mem_req, mem_we,
        output imem_valid, imem_rdata, mem_ready
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the core datapath.
// Owns the PC, the instruction register, both memory handshakes and the datapath strobes.
//
// state   | meaning
// FETCH   | imem_req high, waiting for imem_valid; captures IR and advances PC
// DECODE  | one idle cycle while the decoder registers IR fields
// EXECUTE | alu_en for one cycle; branches update PC here
// MEM     | mem_req high with mem_we stable, waiting for mem_ready
// WB      | reg_we for one cycle, wb_sel picks memory for loads
// HALT    | terminal, only reset leaves it; err marks a handshake timeout
module core_sequencer #(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              MEM_TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    core_sequencer_if.master bus,
    output logic [31:0]      o_ir,
    output logic             o_alu_en,
    output logic             o_reg_we,
    output logic             o_wb_sel,
    output logic [PC_W-1:0]  o_pc,
    output logic             o_halted,
    output logic             o_err,
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd7
    } state_t;

    localparam int              CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit              TO_EN    = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [3:0] FUNCT_CMP = 4'b1010;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [31:0]      r_ir;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;
    logic             r_mem_we;

    state_t           w_state_nxt;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [31:0]      w_ir_nxt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic             w_err_nxt;
    logic             w_mem_we_nxt;

    logic [1:0]        w_op;
    logic [3:0]        w_funct;
    logic              w_timeout;
    logic signed [25:0] w_br_imm;
    logic [PC_W-1:0]   w_br_off;

    assign w_op      = r_ir[27:26];
    assign w_funct   = r_ir[24:21];
    assign w_timeout = TO_EN && (r_wait_cnt == CNT_LAST);
    assign w_br_imm  = {r_ir[23:0], 2'b00};
    // Signed cast sign-extends the word offset to the PC width before the add.
    assign w_br_off  = PC_W'(w_br_imm);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
            r_mem_we   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_err      <= w_err_nxt;
            r_mem_we   <= w_mem_we_nxt;
        end
    end

    // Wait counter defaults to zero so it is already clear whenever FETCH or MEM is entered.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_wait_nxt   = '0;
        w_err_nxt    = r_err;
        w_mem_we_nxt = r_mem_we;

        case (r_state)
            S_FETCH: begin
                if (bus.imem_valid) begin
                    w_ir_nxt    = bus.imem_rdata;
                    w_pc_nxt    = r_pc + PC_W'(4);
                    w_state_nxt = S_DECODE;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_HALT;
                end else begin
                    w_wait_nxt  = r_wait_cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                w_state_nxt = (w_op == 2'b11) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                case (w_op)
                    OP_DP: begin
                        w_state_nxt = (w_funct == FUNCT_CMP) ? S_FETCH : S_WB;
                    end
                    OP_MEM: begin
                        w_mem_we_nxt = ~r_ir[21];
                        w_state_nxt  = S_MEM;
                    end
                    OP_BRANCH: begin
                        w_pc_nxt    = r_pc + w_br_off;
                        w_state_nxt = S_FETCH;
                    end
                    default: begin
                        w_state_nxt = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    w_state_nxt = r_ir[21] ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_HALT;
                end else begin
                    w_wait_nxt  = r_wait_cnt + CNT_W'(1);
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    assign bus.imem_req  = (r_state == S_FETCH);
    assign bus.imem_addr = r_pc;
    assign bus.mem_req   = (r_state == S_MEM);
    assign bus.mem_we    = (r_state == S_MEM) & r_mem_we;

    assign o_ir     = r_ir;
    assign o_alu_en = (r_state == S_EXECUTE);
    assign o_reg_we = (r_state == S_WB);
    assign o_wb_sel = (r_state == S_WB) & (w_op == OP_MEM);
    assign o_pc     = r_pc;
    assign o_halted = (r_state == S_HALT);
    assign o_err    = r_err;
    assign o_state  = r_state;

endmodule
